spi_mem_arbiter: RTL and testbench

Two-port SPI master and arbiter in front of the SPI memory. Requesters issue read/write commands over a valid/ready handshake; the block grants one at a time round-robin and serialises each command into a single 16-bit SPI frame: 7-bit address, R/W bit, 8 data bits. Frame timing is generated from the system clock. The block returns read data, or write completion, tagged with the requester ID.

---
 rtl/spi_mem_arbiter.sv | 93 +++++++++
 tb/tb_spi_mem_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: two-requester round-robin arbiter in front of a 16-bit-frame SPI memory master
module spi_mem_arbiter #(
   parameter int CLKDIV = 2,
   parameter int GAP = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [1:0]  req_rw,
   input  logic [13:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   output logic        rsp_id,
   output logic [7:0]  rsp_rdata,
   output logic        busy,
   output logic        sclk_pin,
   output logic        cs_pin,
   output logic        mosi_pin,
   input  logic        miso_pin
);
   localparam int CW = $clog2(GAP * CLKDIV + CLKDIV + 1);
   localparam logic [CW-1:0] DIV_END = CW'(CLKDIV - 1);
   localparam logic [CW-1:0] GAP_END = CW'(GAP * CLKDIV - 1);

   typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD, ST_GAP} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic [4:0]    half;
   logic [15:0]   sreg;
   logic [7:0]    rdata;
   logic          last, id, rw, win, tick, accept;

   assign win    = &req_valid ? ~last : req_valid[1];
   assign accept = |req_ready;
   assign tick   = cnt == DIV_END;

   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;

   // next-state: each phase ends when its clk-cycle counter expires
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  state_nx = accept ? ST_SETUP : ST_IDLE;
         ST_SETUP: state_nx = tick ? ST_SHIFT : ST_SETUP;
         ST_SHIFT: state_nx = (tick && half == 5'd31) ? ST_HOLD : ST_SHIFT;
         ST_HOLD:  state_nx = tick ? ST_GAP : ST_HOLD;
         ST_GAP:   state_nx = (cnt == GAP_END) ? ST_IDLE : ST_GAP;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // outputs decoded from state; sclk is high on even half-periods of SHIFT
   always_comb begin
      busy      = state != ST_IDLE;
      req_ready = (state == ST_IDLE && rst_n) ? (req_valid & (win ? 2'b10 : 2'b01)) : 2'b00;
      cs_pin    = !(state == ST_SETUP || state == ST_SHIFT || state == ST_HOLD);
      sclk_pin  = state == ST_SHIFT && !half[0];
      mosi_pin  = (state == ST_SETUP || state == ST_SHIFT) && sreg[15];
      rsp_valid = state == ST_GAP && cnt == '0;
      rsp_id    = id;
      rsp_rdata = (rsp_valid && rw) ? rdata : 8'h00;
   end

   // datapath: phase counter, half-period index, command capture, tx/rx shifters
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt   <= '0;
         half  <= '0;
         sreg  <= '0;
         rdata <= '0;
         last  <= 1'b1;
         id    <= 1'b0;
         rw    <= 1'b0;
      end else begin
         cnt  <= (state_nx != state || (state == ST_SHIFT && tick)) ? '0 : cnt + 1'b1;
         half <= state != ST_SHIFT ? 5'd0 : (tick ? half + 5'd1 : half);
         if (accept) begin
            id   <= win;
            last <= win;
            rw   <= req_rw[win];
            sreg <= {win ? req_addr[13:7] : req_addr[6:0], req_rw[win],
                     req_rw[win] ? 8'h00 : (win ? req_wdata[15:8] : req_wdata[7:0])};
         end else if (state == ST_SHIFT && tick && !half[0])
            sreg <= {sreg[14:0], 1'b0};
         if (tick && (state == ST_SETUP || (state == ST_SHIFT && half[0] && half != 5'd31)))
            rdata <= {rdata[6:0], miso_pin};
      end
endmodule

// File: tb/tb_spi_mem_arbiter.sv
// tb_spi_mem_arbiter: directed checks of the SPI arbiter against a small SPI memory model
module tb_spi_mem_arbiter;
   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  rw = '0;
   logic [13:0] addr = '0;
   logic [15:0] wdata = '0;
   logic        miso;
   logic [1:0]  sel = 2'd0;
   int          checks = 0, errors = 0, bad_rdy = 0, busy_rdy = 0;

   logic [1:0] val0 = '0, val1 = '0, val4 = '0, rdy0, rdy1, rdy4;
   logic       rv0, rv1, rv4, rid0, rid1, rid4, bsy0, bsy1, bsy4;
   logic       sck0, sck1, sck4, cs0, cs1, cs4, mo0, mo1, mo4;
   logic [7:0] rd0, rd1, rd4;

   spi_mem_arbiter #(.CLKDIV(2), .GAP(2)) u0 (.clk(clk), .rst_n(rst_n), .req_valid(val0), .req_ready(rdy0),
      .req_rw(rw), .req_addr(addr), .req_wdata(wdata), .rsp_valid(rv0), .rsp_id(rid0), .rsp_rdata(rd0),
      .busy(bsy0), .sclk_pin(sck0), .cs_pin(cs0), .mosi_pin(mo0), .miso_pin(miso));
   spi_mem_arbiter #(.CLKDIV(1), .GAP(1)) u1 (.clk(clk), .rst_n(rst_n), .req_valid(val1), .req_ready(rdy1),
      .req_rw(rw), .req_addr(addr), .req_wdata(wdata), .rsp_valid(rv1), .rsp_id(rid1), .rsp_rdata(rd1),
      .busy(bsy1), .sclk_pin(sck1), .cs_pin(cs1), .mosi_pin(mo1), .miso_pin(miso));
   spi_mem_arbiter #(.CLKDIV(4), .GAP(1)) u4 (.clk(clk), .rst_n(rst_n), .req_valid(val4), .req_ready(rdy4),
      .req_rw(rw), .req_addr(addr), .req_wdata(wdata), .rsp_valid(rv4), .rsp_id(rid4), .rsp_rdata(rd4),
      .busy(bsy4), .sclk_pin(sck4), .cs_pin(cs4), .mosi_pin(mo4), .miso_pin(miso));

   // the memory model and the checks follow whichever instance sel points at
   wire [1:0] m_rdy  = sel == 2'd0 ? rdy0 : sel == 2'd1 ? rdy1 : rdy4;
   wire       m_rv   = sel == 2'd0 ? rv0  : sel == 2'd1 ? rv1  : rv4;
   wire       m_rid  = sel == 2'd0 ? rid0 : sel == 2'd1 ? rid1 : rid4;
   wire [7:0] m_rd   = sel == 2'd0 ? rd0  : sel == 2'd1 ? rd1  : rd4;
   wire       m_bsy  = sel == 2'd0 ? bsy0 : sel == 2'd1 ? bsy1 : bsy4;
   wire       m_sclk = sel == 2'd0 ? sck0 : sel == 2'd1 ? sck1 : sck4;
   wire       m_cs   = sel == 2'd0 ? cs0  : sel == 2'd1 ? cs1  : cs4;
   wire       m_mosi = sel == 2'd0 ? mo0  : sel == 2'd1 ? mo1  : mo4;

   // SPI memory: shifts mosi on sclk rise, commits writes on a complete frame, serves reads from bit 8 on
   logic [15:0] rx = '0, frame = '0;
   logic [6:0]  ra = '0;
   logic [7:0]  mem [128];
   int          rcnt = 0;
   initial for (int i = 0; i < 128; i++) mem[i] = 8'h00;
   always @(posedge m_sclk or posedge m_cs)
      if (m_cs) begin
         if (rcnt == 16) begin
            frame = rx;
            if (!rx[8]) mem[rx[15:9]] = rx[7:0];
         end
         rcnt = 0;
      end else begin
         rx = {rx[14:0], m_mosi};
         rcnt++;
         if (rcnt == 8) ra = rx[7:1];
      end
   assign miso = (rcnt >= 8 && rcnt < 16) ? mem[ra][15 - rcnt] : 1'b0;

   always @(negedge clk) begin
      if (m_rdy == 2'b11) bad_rdy++;
      if (m_bsy && m_rdy != 2'b00) busy_rdy++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_val(input int id, input logic b);
      case (sel)
         2'd0:    val0[id] = b;
         2'd1:    val1[id] = b;
         default: val4[id] = b;
      endcase
   endtask

   // one full command: wait for ready, then check frame timing, frame content and response
   task automatic cmd(input string tag, input int id, input logic r, input logic [6:0] a,
                      input logic [7:0] d, input logic [7:0] e, input int cd, output int w);
      int k, lo, hi, r1, r2;
      logic ps;
      rw[id] = r;
      addr[7*id +: 7] = a;
      wdata[8*id +: 8] = d;
      set_val(id, 1'b1);
      #1;
      w = 0;
      while (!m_rdy[id] && w < 400) begin @(negedge clk); w++; end
      chk({tag, "_ready"}, 32'(m_rdy), 32'(2'b01 << id));
      @(negedge clk);
      set_val(id, 1'b0);
      chk({tag, "_cs_low"}, 32'(m_cs), 0);
      chk({tag, "_busy"}, 32'(m_bsy), 1);
      k = 1; lo = 1; hi = 0; r1 = -1; r2 = -1; ps = m_sclk;
      while (!m_rv && k < 400) begin
         @(negedge clk);
         k++;
         if (!m_cs) lo++;
         if (m_sclk) hi++;
         if (m_sclk && !ps) begin
            if (r1 < 0) r1 = k;
            else if (r2 < 0) r2 = k;
         end
         ps = m_sclk;
      end
      chk({tag, "_latency"}, 32'(k), 32'(34 * cd + 1));
      chk({tag, "_cs_cycles"}, 32'(lo), 32'(34 * cd));
      chk({tag, "_sclk_high"}, 32'(hi), 32'(16 * cd));
      chk({tag, "_sclk_period"}, 32'(r2 - r1), 32'(2 * cd));
      chk({tag, "_frame"}, 32'(frame), 32'({a, r, r ? 8'h00 : d}));
      chk({tag, "_rsp_id"}, 32'(m_rid), 32'(id));
      chk({tag, "_rsp_rdata"}, 32'(m_rd), 32'(r ? e : 8'h00));
      @(negedge clk);
      chk({tag, "_rsp_pulse"}, 32'(m_rv), 0);
   endtask

   initial begin
      int w, n, fc;
      logic ps;
      repeat (2) @(negedge clk);
      chk("rst_cs", 32'(cs0), 1);
      chk("rst_sclk", 32'(sck0), 0);
      chk("rst_mosi", 32'(mo0), 0);
      chk("rst_ready", 32'(rdy0), 0);
      chk("rst_rsp", 32'({rv0, rid0, rd0}), 0);
      chk("rst_busy", 32'(bsy0), 0);
      rst_n = 1'b1;
      @(negedge clk);

      cmd("wr0", 0, 1'b0, 7'h1D, 8'hAA, 8'h00, 2, w);
      cmd("rd1", 1, 1'b1, 7'h1D, 8'h00, 8'hAA, 2, w);

      rst_n = 1'b0;
      @(negedge clk);
      rw = 2'b00;
      addr = {7'h06, 7'h05};
      wdata = {8'h22, 8'h11};
      rst_n = 1'b1;
      val0 = 2'b11;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (!m_rv && n < 400) begin @(negedge clk); n++; end
         chk("cont_rsp_seen", 32'(m_rv), 1);
         chk("cont_grant", 32'(m_rid), 32'(i % 2));
         @(negedge clk);
      end
      val0 = 2'b00;
      repeat (8) @(negedge clk);

      rw[1] = 1'b1;
      val0[1] = 1'b1;
      cmd("stall_a", 0, 1'b0, 7'h07, 8'h77, 8'h00, 2, w);
      cmd("stall_b", 1, 1'b1, 7'h06, 8'h22, 8'h22, 2, w);
      chk("stall_wait", 32'(w), 3);

      rw[0] = 1'b1;
      addr[6:0] = 7'h1D;
      val0[0] = 1'b1;
      n = 0;
      #1;
      while (!rdy0[0] && n < 400) begin @(negedge clk); n++; end
      @(negedge clk);
      val0[0] = 1'b0;
      fc = 0; ps = sck0; n = 0;
      while (fc < 5 && n < 400) begin
         @(negedge clk);
         n++;
         if (ps && !sck0) fc++;
         ps = sck0;
      end
      chk("abort_falls", 32'(fc), 5);
      rst_n = 1'b0;
      #1;
      chk("abort_cs", 32'(cs0), 1);
      chk("abort_sclk", 32'(sck0), 0);
      chk("abort_busy", 32'(bsy0), 0);
      n = 0;
      repeat (4) begin @(negedge clk); if (rv0) n++; end
      rst_n = 1'b1;
      repeat (80) begin @(negedge clk); if (rv0) n++; end
      chk("abort_no_rsp", 32'(n), 0);
      cmd("after_abort", 0, 1'b1, 7'h1D, 8'h00, 8'hAA, 2, w);

      sel = 2'd1;
      cmd("d1_wr", 0, 1'b0, 7'h33, 8'h5C, 8'h00, 1, w);
      cmd("d1_rd", 1, 1'b1, 7'h33, 8'h00, 8'h5C, 1, w);
      repeat (4) @(negedge clk);
      sel = 2'd2;
      cmd("d4_wr", 1, 1'b0, 7'h44, 8'hC3, 8'h00, 4, w);
      cmd("d4_rd", 0, 1'b1, 7'h44, 8'h00, 8'hC3, 4, w);

      chk("ready_onehot", 32'(bad_rdy), 0);
      chk("ready_while_busy", 32'(busy_rdy), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
